// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: hobby-servo PWM with clamped, slew-limited angle applied at frame boundaries
module servo_pwm_gen #(
  parameter int TICK_DIV     = 50,
  parameter int FRAME_US     = 20000,
  parameter int MIN_PULSE_US = 500,
  parameter int US_PER_DEG   = 11,
  parameter int MAX_STEP     = 2,
  parameter int RESET_ANGLE  = 60
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] iAngle,
  input  logic       iAngleValid,
  input  logic       iEnable,
  output logic       oPwm,
  output logic       oFrameStart,
  output logic [7:0] oAngleCur,
  output logic       oSettled
);
  localparam logic [15:0] RST_WIDTH = 16'(MIN_PULSE_US + RESET_ANGLE * US_PER_DEG);
  logic [15:0] presc, us_cnt, us_nxt, width, width_nxt;
  logic [7:0]  target, cur_nxt, up, dn;
  logic        en_lat, en_nxt, tick, boundary;
  // next-state values; the PWM compare uses these post-edge values so pulse and frame start align
  always_comb begin
    tick      = presc == 16'(TICK_DIV - 1);
    boundary  = tick && us_cnt == 16'(FRAME_US - 1);
    us_nxt    = boundary ? 16'd0 : tick ? us_cnt + 16'd1 : us_cnt;
    up        = target - oAngleCur;
    dn        = oAngleCur - target;
    cur_nxt   = !boundary ? oAngleCur :
                target > oAngleCur ? (up > 8'(MAX_STEP) ? oAngleCur + 8'(MAX_STEP) : target) :
                (dn > 8'(MAX_STEP) ? oAngleCur - 8'(MAX_STEP) : target);
    width_nxt = boundary ? 16'(MIN_PULSE_US) + 16'(cur_nxt) * 16'(US_PER_DEG) : width;
    en_nxt    = boundary ? iEnable : en_lat;
  end
  // counters, target/applied angle, and registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      presc       <= '0;
      us_cnt      <= '0;
      target      <= 8'(RESET_ANGLE);
      oAngleCur   <= 8'(RESET_ANGLE);
      width       <= RST_WIDTH;
      en_lat      <= 1'b0;
      oPwm        <= 1'b0;
      oFrameStart <= 1'b0;
      oSettled    <= 1'b1;
    end else begin
      presc       <= tick ? 16'd0 : presc + 16'd1;
      us_cnt      <= us_nxt;
      target      <= iAngleValid ? (iAngle > 8'd180 ? 8'd180 : iAngle) : target;
      oAngleCur   <= cur_nxt;
      width       <= width_nxt;
      en_lat      <= en_nxt;
      oPwm        <= en_nxt && us_nxt < width_nxt;
      oFrameStart <= boundary;
      oSettled    <= oAngleCur == target;
    end
  end
endmodule
